alu_exec_unit: RTL and testbench

Sequencer and register file directly upstream of the combinational `alu`. It accepts one register-register or register-immediate command at a time over a valid/ready handshake and reads the source operands from an internal 32×32 register file. It then drives `alu`'s op1/op2/alu_op inputs, captures result and zero, writes the result back, and reports completion. The unit is strictly serial: one command in flight, so no hazards are possible.

---
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Serial sequencer and 32x32 register file feeding a combinational ALU.
// Sequence per command: IDLE (accept) -> READ -> EXEC -> WB (write-back, done pulse).
module alu_exec_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_imm,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_rd,
  output logic [DATA_W-1:0] done_result,
  output logic              done_zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned OP_W  = 4;
  localparam logic [DATA_W-1:0] SHAMT_MASK = DATA_W'(31);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                use_imm_q, use_imm_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                done_valid_q, done_valid_d;
  logic [ADDR_W-1:0]   done_rd_q, done_rd_d;
  logic [DATA_W-1:0]   done_result_q, done_result_d;
  logic                done_zero_q, done_zero_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];

  logic [DATA_W-1:0]   rs1_val, rs2_val, op2_raw;
  logic                is_shift;

  // Source operand read with x0 hardwired to zero
  always_comb begin
    rs1_val  = (rs1_q == '0) ? '0 : regs_q[rs1_q];
    rs2_val  = (rs2_q == '0) ? '0 : regs_q[rs2_q];
    op2_raw  = use_imm_q ? imm_q : rs2_val;
    is_shift = (op_q == 4'b1000) || (op_q == 4'b1001) || (op_q == 4'b1010);
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    use_imm_d     = use_imm_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_op_d      = alu_op_q;
    done_valid_d  = 1'b0;
    done_rd_d     = done_rd_q;
    done_result_d = done_result_q;
    done_zero_d   = done_zero_q;
    regs_d        = regs_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          rd_d      = cmd_rd;
          rs1_d     = cmd_rs1;
          rs2_d     = cmd_rs2;
          imm_d     = cmd_imm;
          use_imm_d = cmd_use_imm;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        alu_op1_d = rs1_val;
        alu_op2_d = is_shift ? (op2_raw & SHAMT_MASK) : op2_raw;
        alu_op_d  = op_q;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        done_result_d = alu_result;
        done_zero_d   = alu_zero;
        done_rd_d     = rd_q;
        done_valid_d  = 1'b1;
        state_d       = S_WB;
      end
      S_WB: begin
        // x0 stays zero; the done payload still reports the ALU output
        if (rd_q != '0) regs_d[rd_q] = done_result_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_op_q      <= '0;
      done_valid_q  <= 1'b0;
      done_rd_q     <= '0;
      done_result_q <= '0;
      done_zero_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      use_imm_q     <= use_imm_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_op_q      <= alu_op_d;
      done_valid_q  <= done_valid_d;
      done_rd_q     <= done_rd_d;
      done_result_q <= done_result_d;
      done_zero_q   <= done_zero_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_op      = alu_op_q;
  assign done_valid  = done_valid_q;
  assign done_rd     = done_rd_q;
  assign done_result = done_result_q;
  assign done_zero   = done_zero_q;
  assign dbg_data    = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a behavioural ALU attached to its alu_* ports.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0] cmd_imm = '0;
  logic        cmd_use_imm = 1'b0;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [31:0] done_result;
  logic        done_zero;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done_valid(done_valid), .done_rd(done_rd), .done_result(done_result),
    .done_zero(done_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b1000: alu_result = alu_op1 >> alu_op2[4:0];
      4'b1001: alu_result = alu_op1 << alu_op2[4:0];
      4'b1010: alu_result = 32'($signed(alu_op1) >>> alu_op2[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1 v = dbg_data;
  endtask

  // Issue one command from IDLE and collect its completion (lat = cycles after accept cycle)
  task automatic do_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm,
                        output int lat, output logic [31:0] res, output logic z,
                        output logic [4:0] drd);
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm = imm; cmd_use_imm = use_imm; cmd_valid = 1'b1;
    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; res = 'x; z = 1'bx; drd = 'x;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      if (done_valid) begin
        lat = i; res = done_result; z = done_zero; drd = done_rd;
        break;
      end
    end
    @(negedge clk);
    chk("done_single_pulse", 32'(done_valid), 32'd0);
    chk("ready_after_wb", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] res, v;
    logic        z;
    logic [4:0]  drd;
    int          low_cnt;
    bit          seen;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_done_result", done_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ADD immediate: x1 = 0 + 5
    do_cmd(4'b0010, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, lat, res, z, drd);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_result", res, 32'd5);
    chk("add_zero", 32'(z), 32'd0);
    chk("add_rd", 32'(drd), 32'd1);
    rd_reg(5'd1, v); chk("add_x1", v, 32'd5);

    // SUB x2 = x1 - x1
    do_cmd(4'b0110, 5'd2, 5'd1, 5'd1, 32'hDEAD_BEEF, 1'b0, lat, res, z, drd);
    chk("sub_latency", 32'(lat), 32'd3);
    chk("sub_result", res, 32'd0);
    chk("sub_zero", 32'(z), 32'd1);
    rd_reg(5'd2, v); chk("sub_x2", v, 32'd0);

    // SLL with shift amount masked to 5 bits
    do_cmd(4'b0010, 5'd3, 5'd0, 5'd0, 32'd1, 1'b1, lat, res, z, drd);
    rd_reg(5'd3, v); chk("set_x3", v, 32'd1);
    do_cmd(4'b1001, 5'd5, 5'd3, 5'd0, 32'h21, 1'b1, lat, res, z, drd);
    chk("sll_op2_masked", alu_op2, 32'd1);
    chk("sll_result", res, 32'd2);
    rd_reg(5'd5, v); chk("sll_x5", v, 32'd2);

    // Non-shift op passes op2 unmodified
    do_cmd(4'b0010, 5'd4, 5'd0, 5'd0, 32'h8000_0000, 1'b1, lat, res, z, drd);
    chk("add_op2_unmasked", alu_op2, 32'h8000_0000);
    rd_reg(5'd4, v); chk("set_x4", v, 32'h8000_0000);

    // SRA: only imm[4:0]=4 reaches the ALU
    do_cmd(4'b1010, 5'd6, 5'd4, 5'd0, 32'hFFFF_FFE4, 1'b1, lat, res, z, drd);
    chk("sra_op2_masked", alu_op2, 32'd4);
    chk("sra_result", res, 32'hF800_0000);
    chk("sra_op", 32'(alu_op), 32'd10);

    // SRL via register operand: x4 >> (x3=1)
    do_cmd(4'b1000, 5'd11, 5'd4, 5'd3, 32'd0, 1'b0, lat, res, z, drd);
    chk("srl_result", res, 32'h4000_0000);

    // Undefined op writes 0 with zero flag
    do_cmd(4'b1111, 5'd12, 5'd1, 5'd1, 32'd0, 1'b0, lat, res, z, drd);
    chk("undef_result", res, 32'd0);
    chk("undef_zero", 32'(z), 32'd1);

    // x0 protection
    do_cmd(4'b0010, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, lat, res, z, drd);
    chk("x0_result", res, 32'd7);
    chk("x0_done_rd", 32'(drd), 32'd0);
    rd_reg(5'd0, v); chk("x0_reads_zero", v, 32'd0);

    // Back-to-back: x7 = x1 + 10, then x8 = x7 + 1 with cmd_valid held
    @(negedge clk);
    cmd_op = 4'b0010; cmd_rd = 5'd7; cmd_rs1 = 5'd1; cmd_imm = 32'd10;
    cmd_use_imm = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_rd = 5'd8; cmd_rs1 = 5'd7; cmd_imm = 32'd1;
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) break;
      low_cnt++;
      @(negedge clk);
    end
    chk("b2b_ready_low_cycles", 32'(low_cnt), 32'd3);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rd_reg(5'd7, v); chk("b2b_x7", v, 32'd15);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      if (done_valid) begin lat = i; res = done_result; break; end
    end
    chk("b2b_second_latency", 32'(lat), 32'd3);
    chk("b2b_second_result", res, 32'd16);
    @(negedge clk);
    rd_reg(5'd8, v); chk("b2b_x8", v, 32'd16);

    // Reset during EXEC aborts the command
    @(negedge clk);
    cmd_op = 4'b0010; cmd_rd = 5'd9; cmd_rs1 = 5'd0; cmd_imm = 32'd9;
    cmd_use_imm = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("exec_rst_ready", 32'(cmd_ready), 32'd1);
    chk("exec_rst_done_valid", 32'(done_valid), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_valid) seen = 1'b1;
    end
    chk("exec_rst_no_done", 32'(seen), 32'd0);
    chk("exec_rst_idle", 32'(cmd_ready), 32'd1);
    rd_reg(5'd9, v); chk("exec_rst_x9", v, 32'd0);
    rd_reg(5'd1, v); chk("exec_rst_x1_cleared", v, 32'd0);
    do_cmd(4'b0010, 5'd9, 5'd0, 5'd0, 32'd9, 1'b1, lat, res, z, drd);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_result", res, 32'd9);
    rd_reg(5'd9, v); chk("post_rst_x9", v, 32'd9);

    // Mid-cycle reset during WB clears done_valid at once and wipes the register file
    @(negedge clk);
    cmd_op = 4'b0010; cmd_rd = 5'd10; cmd_rs1 = 5'd9; cmd_imm = 32'd3;
    cmd_use_imm = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("wb_done_valid", 32'(done_valid), 32'd1);
    chk("wb_done_result", done_result, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("wb_rst_done_valid", 32'(done_valid), 32'd0);
    chk("wb_rst_ready", 32'(cmd_ready), 32'd1);
    chk("wb_rst_done_result", done_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_reg(5'(a), v);
      chk($sformatf("rst_dbg_x%0d", a), v, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
